// File: rtl/sme_match_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : sme_match_collector_if
// Description : Bundles the SME match stream, the per-packet result view and
//               the statistics counters of sme_match_collector.
//   match_rules_ID/match_last/match_valid : match beat from the SME wrapper
//   match_release                         : ready back to the SME wrapper
//   res_valid/res_count/res_overflow/res_first_id : current result summary
//   rd_idx/rd_data                        : random-access read of the result
//   res_done                              : core releases the current result
//   pkt_cnt/ovf_cnt                       : completed / overflowed packets
//   Modport slave is the collector, master is the SME side plus the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface sme_match_collector_if #(
  parameter int ID_WIDTH  = 32,
  parameter int MAX_RULES = 16,
  parameter int IDX_WIDTH = $clog2(MAX_RULES)
);
  logic [ID_WIDTH-1:0]  match_rules_ID;
  logic                 match_last;
  logic                 match_valid;
  logic                 match_release;
  logic                 res_valid;
  logic [IDX_WIDTH:0]   res_count;
  logic                 res_overflow;
  logic [ID_WIDTH-1:0]  res_first_id;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic [ID_WIDTH-1:0]  rd_data;
  logic                 res_done;
  logic [31:0]          pkt_cnt;
  logic [31:0]          ovf_cnt;

  modport slave (
    input  match_rules_ID, match_last, match_valid, rd_idx, res_done,
    output match_release, res_valid, res_count, res_overflow, res_first_id,
           rd_data, pkt_cnt, ovf_cnt
  );

  modport master (
    output match_rules_ID, match_last, match_valid, rd_idx, res_done,
    input  match_release, res_valid, res_count, res_overflow, res_first_id,
           rd_data, pkt_cnt, ovf_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sme_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : sme_match_collector
// Description : Collects the rule IDs of each packet from the SME match stream
//               into one of two ping-pong banks, dropping zero IDs and
//               back-to-back duplicates, and presents completed packets in
//               order to the core for random-access reading.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : sme_match_collector_if.slave (match stream, result, counters)
// Revision    : 1.0 - initial release
// ============================================================================
module sme_match_collector #(
  parameter int ID_WIDTH  = 32,
  parameter int MAX_RULES = 16,
  parameter int IDX_WIDTH = $clog2(MAX_RULES)
) (
  input  logic                 clk,
  input  logic                 rst,
  sme_match_collector_if.slave bus
);
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_state_t;

  localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH + 1)'(MAX_RULES);

  // Bank storage has no reset; every read path is gated by the bank state
  // and the latched count, so stale contents are never visible.
  logic [ID_WIDTH-1:0]  mem [2][MAX_RULES];

  bank_state_t          state     [2];
  bank_state_t          state_nxt [2];
  logic [IDX_WIDTH:0]   count     [2];
  logic [IDX_WIDTH:0]   count_nxt [2];
  logic                 bank_ovf     [2];
  logic                 bank_ovf_nxt [2];
  logic                 cb, cb_nxt;
  logic                 ob, ob_nxt;
  logic [IDX_WIDTH:0]   wptr, wptr_nxt;
  logic [ID_WIDTH-1:0]  last_id, last_id_nxt;
  logic                 pkt_ovf, pkt_ovf_nxt;
  logic [31:0]          pkt_total, pkt_total_nxt;
  logic [31:0]          ovf_total, ovf_total_nxt;
  logic [ID_WIDTH-1:0]  rd_data;

  logic                 release_ok;
  logic                 accept;
  logic                 candidate;
  logic                 store;
  logic                 discard;
  logic                 ovf_final;
  logic                 res_valid;
  logic                 done_ok;

  assign release_ok = !rst && (state[cb] != ST_FULL);
  assign accept     = bus.match_valid && release_ok;
  // last_id clears to zero and zero is never stored, so a cleared register
  // cannot falsely suppress a real ID.
  assign candidate  = accept && (bus.match_rules_ID != '0) &&
                      (bus.match_rules_ID != last_id);
  assign store      = candidate && (wptr < FULL_COUNT);
  assign discard    = candidate && (wptr == FULL_COUNT);
  assign ovf_final  = pkt_ovf || discard;
  assign res_valid  = (state[ob] == ST_FULL);
  assign done_ok    = bus.res_done && res_valid;

  // Next-state logic for the bank state machines and collect/output pointers.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    bank_ovf_nxt  = bank_ovf;
    cb_nxt        = cb;
    ob_nxt        = ob;
    wptr_nxt      = wptr;
    last_id_nxt   = last_id;
    pkt_ovf_nxt   = ovf_final;
    pkt_total_nxt = pkt_total;
    ovf_total_nxt = ovf_total;

    if (accept) begin
      if (state[cb] == ST_EMPTY) begin
        state_nxt[cb] = ST_FILLING;
      end
      if (store) begin
        wptr_nxt    = wptr + (IDX_WIDTH + 1)'(1);
        last_id_nxt = bus.match_rules_ID;
      end
      if (bus.match_last) begin
        state_nxt[cb]    = ST_FULL;
        count_nxt[cb]    = wptr_nxt;
        bank_ovf_nxt[cb] = ovf_final;
        cb_nxt           = ~cb;
        wptr_nxt         = '0;
        last_id_nxt      = '0;
        pkt_ovf_nxt      = 1'b0;
        pkt_total_nxt    = pkt_total + 32'd1;
        if (ovf_final) begin
          ovf_total_nxt = ovf_total + 32'd1;
        end
      end
    end

    // When cb == ob a last beat cannot coincide with a valid result, so the
    // two updates below always touch different banks.
    if (done_ok) begin
      state_nxt[ob] = ST_EMPTY;
      ob_nxt        = ~ob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state[b]    <= ST_EMPTY;
        count[b]    <= '0;
        bank_ovf[b] <= 1'b0;
      end
      cb        <= 1'b0;
      ob        <= 1'b0;
      wptr      <= '0;
      last_id   <= '0;
      pkt_ovf   <= 1'b0;
      pkt_total <= '0;
      ovf_total <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      bank_ovf  <= bank_ovf_nxt;
      cb        <= cb_nxt;
      ob        <= ob_nxt;
      wptr      <= wptr_nxt;
      last_id   <= last_id_nxt;
      pkt_ovf   <= pkt_ovf_nxt;
      pkt_total <= pkt_total_nxt;
      ovf_total <= ovf_total_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[cb][wptr[IDX_WIDTH-1:0]] <= bus.match_rules_ID;
    end
  end

  // Reads beyond the stored count return zero rather than stale bank data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (res_valid && ({1'b0, bus.rd_idx} < count[ob])) begin
      rd_data <= mem[ob][bus.rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  assign bus.match_release = release_ok;
  assign bus.res_valid     = res_valid;
  assign bus.res_count     = res_valid ? count[ob] : '0;
  assign bus.res_overflow  = res_valid && bank_ovf[ob];
  assign bus.res_first_id  = (res_valid && (count[ob] != '0)) ? mem[ob][0] : '0;
  assign bus.rd_data       = rd_data;
  assign bus.pkt_cnt       = pkt_total;
  assign bus.ovf_cnt       = ovf_total;

endmodule
`default_nettype wire

// File: tb/tb_sme_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_sme_match_collector
// Description : Self-checking bench for sme_match_collector: a table of
//               directed packets, hand-written multi-cycle sequences, and a
//               randomized phase against a list-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_match_collector;
  localparam int NPKT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_pkt = 0;
  int   exp_ovfc = 0;

  always #5 clk = ~clk;

  sme_match_collector_if bus ();

  sme_match_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    int               n;
    logic [0:5][31:0] ids;
    int               cnt;
    logic [0:5][31:0] exp;
    logic             ovf;
  } vec_t;

  vec_t tbl [6];

  // Reference model state for the random phase: one record per packet, with
  // the stored list padded to 16 entries by zeros.
  int          m_cnt [$];
  bit          m_ovf [$];
  logic [31:0] m_ids [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] id, input logic last);
    int w = 0;
    bus.match_rules_ID = id;
    bus.match_last     = last;
    bus.match_valid    = 1'b1;
    while (!bus.match_release && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_beat: release stuck low, got 0 expected 1");
    end else begin
      tick();
    end
    bus.match_valid = 1'b0;
    bus.match_last  = 1'b0;
  endtask

  task automatic read_chk(input string name, input int idx, input logic [31:0] exp);
    bus.rd_idx = 4'(idx);
    tick();
    chk(name, bus.rd_data, exp);
  endtask

  task automatic done_pulse();
    bus.res_done = 1'b1;
    tick();
    bus.res_done = 1'b0;
  endtask

  initial begin
    bus.match_rules_ID = '0;
    bus.match_last     = 1'b0;
    bus.match_valid    = 1'b0;
    bus.rd_idx         = '0;
    bus.res_done       = 1'b0;

    tbl[0] = '{4, {32'd5, 32'd5, 32'd9, 32'd0, 32'd0, 32'd0}, 2,
               {32'd5, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[1] = '{1, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0,
               {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[2] = '{6, {32'd7, 32'd3, 32'd7, 32'd7, 32'd0, 32'd3}, 4,
               {32'd7, 32'd3, 32'd7, 32'd3, 32'd0, 32'd0}, 1'b0};
    tbl[3] = '{3, {32'd0, 32'd0, 32'd42, 32'd0, 32'd0, 32'd0}, 1,
               {32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[4] = '{5, {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0}, 1,
               {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[5] = '{2, {32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0, 32'd0}, 2,
               {32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0};

    // Reset values
    tick();
    chk("release_in_rst", {31'd0, bus.match_release}, 32'd0);
    rst = 1'b0;
    tick();
    chk("release_after_rst", {31'd0, bus.match_release}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_count", 32'(bus.res_count), 32'd0);
    chk("rst_res_overflow", {31'd0, bus.res_overflow}, 32'd0);
    chk("rst_first_id", bus.res_first_id, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 32'd0);
    chk("rst_ovf_cnt", bus.ovf_cnt, 32'd0);

    // Table-driven single packets
    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < tbl[t].n; b++) begin
        send_beat(tbl[t].ids[b], b == tbl[t].n - 1);
      end
      exp_pkt++;
      chk("tbl_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("tbl_res_count", 32'(bus.res_count), 32'(tbl[t].cnt));
      chk("tbl_res_overflow", {31'd0, bus.res_overflow}, {31'd0, tbl[t].ovf});
      chk("tbl_first_id", bus.res_first_id, tbl[t].exp[0]);
      chk("tbl_pkt_cnt", bus.pkt_cnt, 32'(exp_pkt));
      for (int k = 0; k < 6; k++) begin
        read_chk("tbl_rd_data", k, tbl[t].exp[k]);
      end
      done_pulse();
      chk("tbl_released", {31'd0, bus.res_valid}, 32'd0);
    end

    // Overflow: 20 distinct IDs into a 16-entry bank
    for (int i = 1; i <= 20; i++) begin
      send_beat(32'(i), i == 20);
    end
    exp_pkt++;
    exp_ovfc++;
    chk("ovf_count", 32'(bus.res_count), 32'd16);
    chk("ovf_flag", {31'd0, bus.res_overflow}, 32'd1);
    chk("ovf_cnt", bus.ovf_cnt, 32'(exp_ovfc));
    chk("ovf_first", bus.res_first_id, 32'd1);
    read_chk("ovf_entry15", 15, 32'd16);
    read_chk("ovf_entry0", 0, 32'd1);
    done_pulse();

    // Three back-to-back packets with no release in between
    send_beat(32'd11, 1'b0);
    send_beat(32'd12, 1'b1);
    send_beat(32'd21, 1'b1);
    exp_pkt += 2;
    chk("b2b_first_a", bus.res_first_id, 32'd11);
    bus.match_rules_ID = 32'd31;
    bus.match_valid    = 1'b1;
    #1;
    chk("b2b_backpressure", {31'd0, bus.match_release}, 32'd0);
    done_pulse();
    chk("b2b_release_back", {31'd0, bus.match_release}, 32'd1);
    chk("b2b_first_b", bus.res_first_id, 32'd21);
    tick();
    bus.match_valid = 1'b0;
    send_beat(32'd32, 1'b1);
    exp_pkt++;
    chk("b2b_still_b", bus.res_first_id, 32'd21);
    done_pulse();
    chk("b2b_first_c", bus.res_first_id, 32'd31);
    chk("b2b_count_c", 32'(bus.res_count), 32'd2);
    read_chk("b2b_c_entry1", 1, 32'd32);
    done_pulse();

    // res_done without a result is ignored
    done_pulse();
    chk("idle_done_valid", {31'd0, bus.res_valid}, 32'd0);
    send_beat(32'd77, 1'b1);
    exp_pkt++;
    chk("idle_done_next_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("idle_done_next_first", bus.res_first_id, 32'd77);
    done_pulse();

    // Last beat and res_done in the same cycle
    send_beat(32'd50, 1'b1);
    exp_pkt++;
    send_beat(32'd60, 1'b0);
    bus.match_rules_ID = 32'd61;
    bus.match_last     = 1'b1;
    bus.match_valid    = 1'b1;
    bus.res_done       = 1'b1;
    #1;
    chk("sim_release", {31'd0, bus.match_release}, 32'd1);
    tick();
    bus.match_valid = 1'b0;
    bus.match_last  = 1'b0;
    bus.res_done    = 1'b0;
    exp_pkt++;
    chk("sim_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("sim_first", bus.res_first_id, 32'd60);
    chk("sim_count", 32'(bus.res_count), 32'd2);
    chk("sim_pkt_cnt", bus.pkt_cnt, 32'(exp_pkt));
    read_chk("sim_entry1", 1, 32'd61);
    done_pulse();
    chk("sim_drained", {31'd0, bus.res_valid}, 32'd0);

    // Reset mid-packet
    send_beat(32'd91, 1'b0);
    send_beat(32'd92, 1'b0);
    send_beat(32'd93, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_release", {31'd0, bus.match_release}, 32'd0);
    chk("mid_rst_pkt_cnt", bus.pkt_cnt, 32'd0);
    rst = 1'b0;
    tick();
    exp_pkt  = 0;
    exp_ovfc = 0;
    chk("mid_rst_release_back", {31'd0, bus.match_release}, 32'd1);
    send_beat(32'd95, 1'b0);
    send_beat(32'd96, 1'b1);
    exp_pkt++;
    chk("post_rst_count", 32'(bus.res_count), 32'd2);
    chk("post_rst_first", bus.res_first_id, 32'd95);
    chk("post_rst_pkt_cnt", bus.pkt_cnt, 32'd1);
    read_chk("post_rst_entry1", 1, 32'd96);
    read_chk("post_rst_entry2", 2, 32'd0);
    done_pulse();

    // Randomized phase: producer and consumer run concurrently
    fork
      begin : producer
        logic [31:0] stored [$];
        logic [31:0] id;
        bit          povf;
        int          n;
        int          style;
        for (int p = 0; p < NPKT; p++) begin
          stored.delete();
          povf  = 1'b0;
          n     = $urandom_range(1, 24);
          style = $urandom_range(0, 2);
          for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 9) < 2) id = 32'd0;
            else if (style == 0) id = 32'($urandom_range(1, 4));
            else if (style == 1) id = 32'(p * 100 + b + 1);
            else id = $urandom;
            if (id != 0 && (stored.size() == 0 || id != stored[$])) begin
              if (stored.size() < 16) stored.push_back(id);
              else povf = 1'b1;
            end
            if (b == n - 1) begin
              m_cnt.push_back(stored.size());
              m_ovf.push_back(povf);
              for (int k = 0; k < 16; k++) begin
                m_ids.push_back(k < stored.size() ? stored[k] : 32'd0);
              end
            end
            if ($urandom_range(0, 3) == 0) tick();
            send_beat(id, b == n - 1);
          end
        end
      end
      begin : consumer
        int consumed = 0;
        int cyc = 0;
        int idx;
        logic [31:0] ids [16];
        while (consumed < NPKT && cyc < 40000) begin
          if (bus.res_valid && $urandom_range(0, 1) == 1) begin
            if (m_cnt.size() == 0) begin
              chk("rnd_unexpected_result", {31'd0, bus.res_valid}, 32'd0);
              tick();
            end else begin
              for (int k = 0; k < 16; k++) ids[k] = m_ids.pop_front();
              chk("rnd_count", 32'(bus.res_count), 32'(m_cnt[0]));
              chk("rnd_overflow", {31'd0, bus.res_overflow}, {31'd0, m_ovf[0]});
              chk("rnd_first", bus.res_first_id, ids[0]);
              idx = $urandom_range(0, 15);
              read_chk("rnd_rd_data", idx, ids[idx]);
              exp_pkt++;
              if (m_ovf[0]) exp_ovfc++;
              void'(m_cnt.pop_front());
              void'(m_ovf.pop_front());
              done_pulse();
              consumed++;
              cyc += 2;
            end
          end else begin
            tick();
          end
          cyc++;
        end
        if (consumed < NPKT) begin
          checks++;
          errors++;
          $display("FAIL rnd_timeout: consumed %0d expected %0d", consumed, NPKT);
        end
      end
    join

    chk("final_pkt_cnt", bus.pkt_cnt, 32'(exp_pkt));
    chk("final_ovf_cnt", bus.ovf_cnt, 32'(exp_ovfc));
    chk("final_idle", {31'd0, bus.res_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sme_match_collector.md
# sme_match_collector

Per-packet collector for rule IDs leaving the Pigasus SME wrapper. It consumes the 32-bit match stream and drops zero (no-match) IDs and back-to-back duplicates. Up to MAX_RULES IDs per packet are stored in one of two ping-pong banks. Each completed packet is presented to the RISC-V core as a result: count, overflow flag and a random-access read port. The core releases the bank when it is done.

## Interface
- ID_WIDTH, 32, rule ID width.
- MAX_RULES, 16, stored IDs per packet; power of two.
- IDX_WIDTH, $clog2(MAX_RULES), read index width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- match_rules_ID  in  ID_WIDTH  rule ID beat from the SME wrapper.
- match_last  in  1  last beat of the packet's match list.
- match_valid  in  1  beat valid.
- match_release  out  1  ready to the SME wrapper; a beat transfers when match_valid && match_release.
- res_valid  out  1  a completed packet result is available.
- res_count  out  IDX_WIDTH+1  number of stored IDs, 0..MAX_RULES.
- res_overflow  out  1  at least one distinct nonzero ID was discarded because the bank was full.
- res_first_id  out  ID_WIDTH  entry 0, or 0 when res_count==0.
- rd_idx  in  IDX_WIDTH  read index into the result bank.
- rd_data  out  ID_WIDTH  registered read data.
- res_done  in  1  single-cycle pulse; the core releases the current result.
- pkt_cnt  out  32  completed packets, wraps.
- ovf_cnt  out  32  packets with overflow, wraps.

## Operation
- Two banks, each MAX_RULES×ID_WIDTH, with per-bank state EMPTY / FILLING / FULL.
- Pointer cb selects the collect bank; pointer ob selects the output bank. Both are 0 at reset.
- match_release = !rst && state[cb] != FULL.
- Accepted beat in bank cb:
  - EMPTY goes to FILLING on the first accepted beat.
  - An ID of 0 is not stored.
  - An ID equal to the most recently stored ID of the same packet is not stored.
  - Otherwise, if wptr < MAX_RULES: store at wptr, then wptr++.
  - Otherwise the ID is discarded and the ovf flag is set.
- Accepted beat with match_last:
  - Apply the store rule above to that beat first.
  - Latch count = final wptr and the ovf flag into bank cb; state[cb] becomes FULL.
  - cb toggles; wptr, the last-stored register and the ovf flag clear.
  - pkt_cnt++; ovf_cnt++ if ovf.
- A last beat whose ID is 0 and arrives with no prior stores yields a result with res_count=0.
- Output side: res_valid = state[ob]==FULL. res_count, res_overflow and res_first_id come from bank ob.
- res_done while res_valid: state[ob] becomes EMPTY and ob toggles.
- res_done while !res_valid is ignored.
- Results are delivered strictly in packet order.
- Duplicate suppression covers consecutive stored IDs only. Non-adjacent repeats are stored.

## Timing
- Reset values:
  - match_release 0 during rst, 1 in the first cycle after rst.
  - res_valid 0, res_count 0, res_overflow 0, res_first_id 0, rd_data 0, pkt_cnt 0, ovf_cnt 0.
  - Both banks EMPTY.
- Latency: res_valid rises the cycle after the last beat is accepted, provided ob points to that bank.
- rd_data = bank[ob][rd_idx] one cycle after rd_idx is presented.
- rd_data = 0 if rd_idx >= res_count or !res_valid.
- Throughput: one beat per cycle. match_release drops only when both banks are FULL.
- match_release is high again the cycle after res_done frees a bank.
- Simultaneous last-beat accept into cb and res_done on ob (the other bank): both take effect in the same cycle. Backpressure never appears.
- rst mid-packet or mid-result discards all state. Partial packets produce no result.
- Counters wrap 0xFFFFFFFF → 0.

## Test plan
- Single packet with beats 5, 5, 9, 0(last) → res_valid next cycle; res_count=2; reads rd_idx 0,1,2 → 5, 9, 0; res_overflow=0; pkt_cnt=1.
- Packet with only 0(last) → res_count=0, res_first_id=0, res_overflow=0.
- Packet with 20 distinct IDs 1..20, last on 20 (MAX_RULES=16) → res_count=16; entry 15 = 16; res_overflow=1; ovf_cnt=1.
- Three back-to-back packets with no res_done → two results held, match_release=0 on the third packet's first beat. One res_done → release high the next cycle and the third packet completes. Results are read in order 1, 2, 3.
- res_done pulsed with res_valid=0 → no state change. res_done in the same cycle as another packet's last beat → both results are tracked correctly; pkt_cnt increments once per packet.
- rst asserted mid-packet after 3 beats → match_release=0, then 1 after rst. The next full packet reports only its own IDs; pkt_cnt counts only post-reset packets.
